miriscv_lsu: RTL
================

Name: miriscv_lsu

Overview:
- Load/store unit: the initiator side of the core's data memory interface.
- Takes load/store requests from the execute stage and drives the word-wide, byte-enabled memory request bus.
- Stalls the core for the memory's one-cycle registered read latency, then returns sign/zero-extended load data.
- Sits between the core datapath/decoder and the data port of the unified RAM.

Parameters:
- MISALIGN_CHECK, 1: 1 = misaligned half/word accesses raise lsu_exc_o and issue nothing. 0 = address low bits are forced to natural alignment and the access proceeds.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, synchronous, active-low
- lsu_req_i  input  1  core requests a memory access this cycle
- lsu_we_i  input  1  1 = store, 0 = load
- lsu_size_i  input  3  RISC-V funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- lsu_addr_i  input  32  effective byte address
- lsu_data_i  input  32  store data, right-aligned
- lsu_data_o  output  32  extended load result
- lsu_stall_req_o  output  1  core must hold the pipeline
- lsu_exc_o  output  1  misaligned or illegal-size request
- data_req_o  output  1  memory request strobe
- data_we_o  output  1  memory write enable
- data_be_o  output  4  byte enables
- data_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- data_wdata_o  output  32  lane-replicated store data
- data_rdata_i  input  32  memory read data; valid the cycle after data_req_o

Behaviour:
- Reset: clock and reset as stated in Ports. While rst_n_i=0:
  - all outputs are forced to 0;
  - the FSM goes to IDLE on the next edge;
  - a reset during WAIT discards the access and returns no data.
- FSM has two states, IDLE and WAIT.
- IDLE, lsu_req_i=1, request legal:
  - data_req_o=1 combinationally; data_we_o, data_be_o, data_addr_o and data_wdata_o are valid in the same cycle;
  - lsu_stall_req_o=1;
  - next state is WAIT.
- IDLE, lsu_req_i=0: all memory outputs are 0, stall=0.
- WAIT (always exactly one cycle):
  - data_req_o=0 (the core still holds lsu_req_i=1; no re-issue);
  - lsu_stall_req_o=0;
  - for a load, lsu_data_o is extracted from data_rdata_i;
  - next state is IDLE.
- Latency: every legal access takes exactly 2 cycles. Back-to-back accesses issue on cycles 0, 2, 4, ...
- Byte enables and write data by size (o = addr[1:0]):
  - byte: be = 0001<<o; wdata = {4{data[7:0]}}
  - half: be = 0011<<(2*addr[1]); wdata = {2{data[15:0]}}
  - word: be = 1111; wdata = data
  - loads drive the same be pattern with data_we_o=0.
- Load extraction:
  - selects byte o or half addr[1] of data_rdata_i;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- lsu_data_o=0 in IDLE and for stores.
- Exception:
  - lsu_exc_o=1 combinationally in IDLE with lsu_req_i=1 when the size is illegal (011, 11x, or store with size[2]=1), or when MISALIGN_CHECK=1 and the access is misaligned (half with addr[0]=1; word with addr[1:0]≠0);
  - no data_req_o, no stall, state stays IDLE;
  - lsu_exc_o=0 in WAIT.
- MISALIGN_CHECK=0: half ignores addr[0]; word ignores addr[1:0]. Illegal sizes still raise lsu_exc_o.
- lsu_req_i is ignored in WAIT; lsu_we_i, lsu_size_i and lsu_addr_i must be held stable by the core through WAIT.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles with lsu_req_i=1 -> all outputs 0; first cycle after release issues data_req_o=1.
- SW: addr 0x10, data 0xDEADBEEF -> cycle 0: req=1, we=1, be=1111, addr=0x10, wdata=0xDEADBEEF, stall=1; cycle 1: req=0, stall=0.
- SB: addr 0x13, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr=0x10.
- Loads with memory returning 0x8070F081 at addr 0x20:
  - LB @0x20 -> 0xFFFFFF81
  - LBU @0x20 -> 0x00000081
  - LH @0x22 -> 0xFFFF8070
  - LHU @0x22 -> 0x00008070
  - LW @0x20 -> 0x8070F081
  - each result appears in the WAIT cycle; stall is high only in cycle 0.
- Misaligned: LW @0x21 and LH @0x23 (MISALIGN_CHECK=1) -> lsu_exc_o=1, data_req_o=0, stall=0. Size 011 -> lsu_exc_o=1.
- Back-to-back and reset mid-access:
  - LW then SW -> requests on cycles 0 and 2 only;
  - rst_n_i=0 during WAIT -> lsu_data_o=0, FSM returns to IDLE, no re-issue after release until lsu_req_i is seen in IDLE.

Source files
------------

// File: rtl/miriscv_lsu.sv
// Load/store unit: initiator side of the core's data memory port.
// Issues a word-wide, byte-enabled request in IDLE, stalls the core for one
// cycle while the memory's registered read completes, then returns the
// sign/zero-extended load result in WAIT.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   lsu_req_i/we_i        core access request, 1 = store
//   lsu_size_i            RISC-V funct3 access size
//   lsu_addr_i/data_i     effective byte address, right-aligned store data
//   lsu_data_o            extended load result (valid in WAIT)
//   lsu_stall_req_o       hold the pipeline (issue cycle)
//   lsu_exc_o             misaligned or illegal-size request
//   data_*                memory request bus; data_rdata_i valid one cycle after data_req_o
module miriscv_lsu #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_exc_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic        w_size_illegal;
    logic        w_misaligned;
    logic        w_exc_cond;
    logic [1:0]  w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_rdata_shift;
    logic [31:0] w_load_data;

    // Access decode. The core holds we/size/addr stable through WAIT, so the
    // same decode serves both the issue cycle and the load extraction.
    always_comb begin
        w_size_illegal = (lsu_size_i == 3'b011) || (lsu_size_i[2:1] == 2'b11) ||
                         (lsu_we_i && lsu_size_i[2]);
        w_misaligned = 1'b0;
        w_offset     = 2'b00;
        w_be         = 4'b1111;
        w_wdata      = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                w_offset = lsu_addr_i[1:0];
                w_be     = 4'b0001 << w_offset;
                w_wdata  = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = lsu_addr_i[0];
                // Without the misalign check, addr[0] is dropped (natural alignment).
                w_offset     = {lsu_addr_i[1], 1'b0};
                w_be         = 4'b0011 << w_offset;
                w_wdata      = {2{lsu_data_i[15:0]}};
            end
            default: begin
                w_misaligned = (lsu_addr_i[1:0] != 2'b00);
            end
        endcase
        w_exc_cond = w_size_illegal || (MISALIGN_CHECK && w_misaligned);

        w_rdata_shift = 16'(data_rdata_i >> {w_offset, 3'b000});
        case (lsu_size_i[1:0])
            2'b00: w_load_data = lsu_size_i[2] ? {24'b0, w_rdata_shift[7:0]}
                                               : {{24{w_rdata_shift[7]}}, w_rdata_shift[7:0]};
            2'b01: w_load_data = lsu_size_i[2] ? {16'b0, w_rdata_shift}
                                               : {{16{w_rdata_shift[15]}}, w_rdata_shift};
            default: w_load_data = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        lsu_data_o      = 32'b0;
        lsu_stall_req_o = 1'b0;
        lsu_exc_o       = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0;
        data_addr_o     = 32'b0;
        data_wdata_o    = 32'b0;
        // Outputs stay forced to zero while reset is asserted.
        if (rst_n_i) begin
            case (r_state)
                StIdle: begin
                    if (lsu_req_i) begin
                        if (w_exc_cond) begin
                            lsu_exc_o = 1'b1;
                        end else begin
                            data_req_o      = 1'b1;
                            data_we_o       = lsu_we_i;
                            data_be_o       = w_be;
                            data_addr_o     = {lsu_addr_i[31:2], 2'b00};
                            data_wdata_o    = w_wdata;
                            lsu_stall_req_o = 1'b1;
                            w_state_next    = StWait;
                        end
                    end
                end
                StWait: begin
                    if (!lsu_we_i) begin
                        lsu_data_o = w_load_data;
                    end
                    w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

endmodule
